// File: rtl/half_adder_sync.sv
`default_nettype none
// ============================================================================
//  Module   : half_adder_sync
//  Purpose  : Bit-wise half adder with independent lanes. Always-live
//             combinational sum/carry, plus main outputs that are either
//             registered with a valid qualifier (REG_OUT=1) or a direct
//             pass-through of the combinational result (REG_OUT=0).
//  Revision : 1.0  initial release
// ============================================================================
module half_adder_sync #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_comb,
  output logic [WIDTH-1:0] carry_comb
);

  // Lanes never interact, so the whole vector is one XOR and one AND.
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  assign w_sum      = a ^ b;
  assign w_carry    = a & b;
  assign sum_comb   = w_sum;
  assign carry_comb = w_carry;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;
      logic             r_out_valid;

      // Capture on valid, hold data otherwise; valid is a one-cycle pulse
      // per accepted input. Reset clears everything asynchronously.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum       <= '0;
          r_carry     <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= in_valid;
          if (in_valid) begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
          end
        end
      end

      assign sum       = r_sum;
      assign carry     = r_carry;
      assign out_valid = r_out_valid;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic w_unused;
      assign w_unused  = clk ^ rst;

      assign sum       = w_sum;
      assign carry     = w_carry;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_half_adder_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_half_adder_sync
//  Purpose  : Directed, self-checking bench for half_adder_sync covering the
//             registered 1-bit and 8-bit builds and the combinational build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_half_adder_sync;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=1, REG_OUT=1
  logic       iv1, a1, b1;
  logic       s1, c1, v1, sc1, cc1;
  // WIDTH=8, REG_OUT=1
  logic       iv8;
  logic [7:0] a8, b8, s8, c8, sc8, cc8;
  logic       v8;
  // WIDTH=4, REG_OUT=0
  logic       iv4;
  logic [3:0] a4, b4, s4, c4, sc4, cc4;
  logic       v4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  half_adder_sync #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1),
    .sum(s1), .carry(c1), .out_valid(v1), .sum_comb(sc1), .carry_comb(cc1)
  );

  half_adder_sync #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8),
    .sum(s8), .carry(c8), .out_valid(v8), .sum_comb(sc8), .carry_comb(cc8)
  );

  half_adder_sync #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4),
    .sum(s4), .carry(c4), .out_valid(v4), .sum_comb(sc4), .carry_comb(cc4)
  );

  typedef struct {
    logic a;
    logic b;
    logic exp_sum;
    logic exp_carry;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0;

    // Reset state, with valid asserted to show reset dominates the clock.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("rst_sum",    {31'd0, s1}, 32'd0);
    check("rst_carry",  {31'd0, c1}, 32'd0);
    check("rst_valid",  {31'd0, v1}, 32'd0);
    check("rst_valid8", {31'd0, v8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    iv1 = 1'b0;

    // Registered truth table, back-to-back.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv1 = 1'b1; a1 = vecs[i].a; b1 = vecs[i].b;
      @(posedge clk); #1;
      check($sformatf("reg_sum[%0d]", i),   {31'd0, s1}, {31'd0, vecs[i].exp_sum});
      check($sformatf("reg_carry[%0d]", i), {31'd0, c1}, {31'd0, vecs[i].exp_carry});
      check($sformatf("reg_valid[%0d]", i), {31'd0, v1}, 32'd1);
      check($sformatf("invariant[%0d]", i), {31'd0, s1 & c1}, 32'd0);
    end

    // Combinational path, independent of valid and clock.
    @(negedge clk);
    iv1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = vecs[i].a; b1 = vecs[i].b;
      #0;
      check($sformatf("comb_sum[%0d]", i),   {31'd0, sc1}, {31'd0, vecs[i].exp_sum});
      check($sformatf("comb_carry[%0d]", i), {31'd0, cc1}, {31'd0, vecs[i].exp_carry});
      #2;
    end

    // Hold: capture 1+1, then drop valid with new data on the inputs.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    check("hold_sum",   {31'd0, s1}, 32'd0);
    check("hold_carry", {31'd0, c1}, 32'd1);
    check("hold_valid", {31'd0, v1}, 32'd0);
    @(posedge clk); #1;
    check("hold2_carry", {31'd0, c1}, 32'd1);

    // Async reset between edges while a result with carry=1 is valid.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_carry", {31'd0, c1}, 32'd1);
    check("pre_rst_valid", {31'd0, v1}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_sum",   {31'd0, s1}, 32'd0);
    check("async_carry", {31'd0, c1}, 32'd0);
    check("async_valid", {31'd0, v1}, 32'd0);
    @(posedge clk); #1;
    check("held_rst_carry", {31'd0, c1}, 32'd0);
    check("held_rst_valid", {31'd0, v1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_sum",   {31'd0, s1}, 32'd1);
    check("post_rst_carry", {31'd0, c1}, 32'd0);
    check("post_rst_valid", {31'd0, v1}, 32'd1);
    @(negedge clk);
    iv1 = 1'b0;

    // WIDTH=8 registered lanes.
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'hAA;
    @(posedge clk); #1;
    check("w8_sum",   {24'd0, s8}, 32'h5A);
    check("w8_carry", {24'd0, c8}, 32'hA0);
    check("w8_valid", {31'd0, v8}, 32'd1);
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F;
    @(posedge clk); #1;
    check("w8b_sum",   {24'd0, s8}, 32'h33);
    check("w8b_carry", {24'd0, c8}, 32'h0C);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    check("w8_hold_sum", {24'd0, s8}, 32'h33);
    check("w8_hold_valid", {31'd0, v8}, 32'd0);

    // WIDTH=4 combinational build.
    iv4 = 1'b1; a4 = 4'hC; b4 = 4'h6;
    #1;
    check("w4_sum",   {28'd0, s4}, 32'hA);
    check("w4_carry", {28'd0, c4}, 32'h4);
    check("w4_valid", {31'd0, v4}, 32'd1);
    iv4 = 1'b0; a4 = 4'h9; b4 = 4'hB;
    #1;
    check("w4b_sum",   {28'd0, s4}, 32'h2);
    check("w4b_carry", {28'd0, c4}, 32'h9);
    check("w4b_valid", {31'd0, v4}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
